elbeth_memory_dp: RTL and testbench
===================================

# elbeth_memory_dp

Dual-port, parametrised main memory for the ELBETH core: one instruction-fetch read port and one data load/store port share a single word array. Both ports use a one-cycle request/response protocol, byte-granular writes, alignment and range checking, and a sticky fault-capture register. Sits between the fetch/memory pipeline stages and replaces the single-port instruction memory.

## Interface
- AW, 32, byte-address width of both ports
- DW, 32, data word width; multiple of 8
- DEPTH, 1024, number of DW-bit words
- BASE, 32'h00000000, byte address of word 0
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request strobe
- if_addr  in  AW  fetch byte address
- if_valid  out  1  fetch response valid
- if_rdata  out  DW  fetched word
- if_exc  out  2  fetch exception code
- d_req  in  1  data request strobe
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  store byte enables
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_valid  out  1  data response valid
- d_rdata  out  DW  load data
- d_exc  out  2  data exception code
- fault_clr  in  1  clears the fault capture
- fault_valid  out  1  a fault has been captured
- fault_addr  out  AW  address of first captured fault
- fault_code  out  2  code of first captured fault

## Operation
- Clock is `clk`; reset is `rst`, synchronous and active-high.
- OFF = log2(DW/8). A request is in range iff addr >= BASE and (addr-BASE)>>OFF < DEPTH. It is aligned iff addr[OFF-1:0] == 0.
- Exception codes: 2'b00 ok, 2'b01 fetch fault, 2'b10 store fault, 2'b11 load fault. Both out-of-range and misaligned accesses fault.
- Fetch: if_req with a good address returns the word with if_exc=00. A faulting fetch returns if_rdata=0 and if_exc=01.
- Load: d_req with d_we=0 returns the word with d_exc=00. A faulting load returns d_rdata=0 and d_exc=11.
- Store: d_req with d_we=1 writes each byte lane i where d_be[i]=1; the other lanes are preserved. d_rdata is 0.
  - A faulting store writes nothing and returns d_exc=10.
  - d_be=0 is a legal no-op store with d_exc=00.
- Fault capture: on the first faulting response while fault_valid=0, latch fault_addr and fault_code and set fault_valid.
  - Later faults do not overwrite the capture.
  - fault_clr clears fault_valid at the next edge.
  - If fault_clr and a new fault coincide, the new fault is captured (fault_valid stays 1).
  - If both ports fault in the same cycle, the data port wins.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: if_valid=0, if_rdata=0, if_exc=00, d_valid=0, d_rdata=0, d_exc=00, fault_valid=0, fault_addr=0, fault_code=00.
- Latency is exactly one cycle. A request sampled at edge N produces *_valid=1 with data/exc for one cycle after edge N.
- No request means *_valid=0 next cycle; rdata and exc are then 0.
- Both ports accept a request every cycle. There is no back-pressure and no ready signal.
- A store committed at edge N is visible to any read sampled at edge N+1 or later.
- Same-cycle fetch and store to the same word: see Configuration.
- A request sampled together with rst=1 is dropped; there is no response and no write.

## Configuration
- `ELBETH_MEM_BYPASS_EN` controls forwarding when a fetch and a store target the same word in the same cycle.
  - Defined: if_rdata returns the merged word, i.e. the stored bytes replace their lanes and the other lanes keep the old value.
  - Undefined: if_rdata returns the pre-store word (read-before-write).
- Loads never alias a same-cycle store, because one port cannot issue both.

## Test plan
- Reset with all requests high -> next cycle every output is 0 and no write occurs; a later load of 0x0 returns undefined/initial contents with d_exc=00.
- Store 0xDEADBEEF to 0x10 with d_be=1111, then store 0x000000AA with d_be=0001, then load 0x10 -> d_rdata=0xDEADBEAA one cycle after the load request.
- Fetch 0x1002 -> if_exc=01, if_rdata=0, fault_valid=1, fault_addr=0x1002, fault_code=01. A following load at 4*DEPTH -> d_exc=11 and the fault capture is unchanged.
- Same cycle: faulting fetch, faulting store at 4*DEPTH+4, and fault_clr=1 -> fault_code=10 and fault_addr=4*DEPTH+4 (data port wins, new fault overrides the clear).
- Word 0x20 holds 0x11111111. In the same cycle, store 0x22222222 with d_be=0011 and fetch 0x20 -> if_rdata=0x11112222 with the macro defined, 0x11111111 without.
- Back-to-back fetches to 0x0, 0x4, 0x8 on three consecutive cycles -> three consecutive if_valid pulses, each carrying the correct word.

Source files
------------

// File: rtl/elbeth_memory_dp.sv
// elbeth_memory_dp: dual-port main memory for the ELBETH core.
// One instruction-fetch read port and one data load/store port share a single
// word array. Both ports have a one-cycle request/response protocol with
// alignment and range checking, and a sticky fault-capture register records
// the first faulting access.
//
// Optional feature macro: ELBETH_MEM_BYPASS_EN
//   defined   -> a fetch that hits the word being stored in the same cycle
//                returns the merged (post-store) word
//   undefined -> such a fetch returns the pre-store word (read-before-write)
module elbeth_memory_dp #(
    parameter int            AW    = 32,
    parameter int            DW    = 32,
    parameter int            DEPTH = 1024,
    parameter logic [AW-1:0] BASE  = '0
) (
    input  logic            clk,
    input  logic            rst,
    // instruction-fetch port
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_valid,
    output logic [DW-1:0]   if_rdata,
    output logic [1:0]      if_exc,
    // data load/store port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_valid,
    output logic [DW-1:0]   d_rdata,
    output logic [1:0]      d_exc,
    // fault capture
    input  logic            fault_clr,
    output logic            fault_valid,
    output logic [AW-1:0]   fault_addr,
    output logic [1:0]      fault_code
);

    localparam int NB  = DW / 8;
    localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] ALIGN_MASK = AW'((1 << OFF) - 1);
    localparam logic [AW:0]   DEPTH_W    = (AW + 1)'(DEPTH);

    localparam logic [1:0] EXC_OK    = 2'b00;
    localparam logic [1:0] EXC_FETCH = 2'b01;
    localparam logic [1:0] EXC_STORE = 2'b10;
    localparam logic [1:0] EXC_LOAD  = 2'b11;

    // An address is usable when it lies inside the window and is word aligned.
    function automatic logic addr_good(input logic [AW-1:0] addr);
        logic [AW-1:0] offset;
        offset = addr - BASE;
        return (addr >= BASE)
            && ({1'b0, offset >> OFF} < DEPTH_W)
            && ((addr & ALIGN_MASK) == '0);
    endfunction

    // Word index of an address; only meaningful when addr_good() holds.
    function automatic logic [IW-1:0] word_index(input logic [AW-1:0] addr);
        return IW'((addr - BASE) >> OFF);
    endfunction

    logic [DW-1:0] mem [DEPTH];

    logic          if_ok;
    logic          d_ok;
    logic [IW-1:0] if_idx;
    logic [IW-1:0] d_idx;
    logic          store_en;
    logic [DW-1:0] fetch_word;
    logic [DW-1:0] load_word;
    logic          if_fault;
    logic          d_fault;

    // Decode both requests and form the words each port will return.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path can leave
        // one unassigned and infer a latch.
        if_ok      = addr_good(if_addr);
        d_ok       = addr_good(d_addr);
        if_idx     = word_index(if_addr);
        d_idx      = word_index(d_addr);
        if_fault   = if_req && !if_ok;
        d_fault    = d_req && !d_ok;
        store_en   = !rst && d_req && d_we && d_ok;
        fetch_word = mem[if_idx];
        load_word  = mem[d_idx];
`ifdef ELBETH_MEM_BYPASS_EN
        // Forward the stored lanes into a fetch of the same word.
        if (store_en && if_req && if_ok && (if_idx == d_idx)) begin
            for (int i = 0; i < NB; i++) begin
                if (d_be[i]) begin
                    fetch_word[8*i +: 8] = d_wdata[8*i +: 8];
                end
            end
        end
`endif
    end

    // Byte-lane store into the shared word array.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch on purpose; contents are
        // undefined until written, which keeps it mappable onto block RAM.
        // The write is still suppressed while rst is high.
        if (store_en) begin
            for (int i = 0; i < NB; i++) begin
                if (d_be[i]) begin
                    // NOTE: non-blocking so the fetch/load reads above see
                    // the pre-store word in this same cycle.
                    mem[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered one-cycle responses for both ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_rdata <= '0;
            if_exc   <= EXC_OK;
            d_valid  <= 1'b0;
            d_rdata  <= '0;
            d_exc    <= EXC_OK;
        end else begin
            if_valid <= if_req;
            if_rdata <= (if_req && if_ok) ? fetch_word : '0;
            if_exc   <= if_fault ? EXC_FETCH : EXC_OK;
            d_valid  <= d_req;
            d_rdata  <= (d_req && !d_we && d_ok) ? load_word : '0;
            d_exc    <= !d_fault ? EXC_OK : (d_we ? EXC_STORE : EXC_LOAD);
        end
    end

    // Sticky capture of the first fault; data port has priority, and a new
    // fault arriving with fault_clr re-arms the capture instead of clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
            fault_code  <= EXC_OK;
        end else if ((d_fault || if_fault) && (!fault_valid || fault_clr)) begin
            fault_valid <= 1'b1;
            fault_addr  <= d_fault ? d_addr : if_addr;
            fault_code  <= d_fault ? (d_we ? EXC_STORE : EXC_LOAD) : EXC_FETCH;
        end else if (fault_clr) begin
            fault_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_elbeth_memory_dp.sv
// Self-checking bench for elbeth_memory_dp: directed steps from the test plan
// followed by randomized traffic, all compared against a word-array model
// that applies the memory's rules directly. Honours ELBETH_MEM_BYPASS_EN.
module tb_elbeth_memory_dp;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_valid;
    logic [31:0]   if_rdata;
    logic [1:0]    if_exc;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [3:0]    d_be = '0;
    logic [31:0]   d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_valid;
    logic [31:0]   d_rdata;
    logic [1:0]    d_exc;
    logic          fault_clr = 1'b0;
    logic          fault_valid;
    logic [31:0]   fault_addr;
    logic [1:0]    fault_code;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] mdl [DEPTH];
    bit          m_fv = 1'b0;
    logic [31:0] m_fa = '0;
    logic [1:0]  m_fc = '0;

    elbeth_memory_dp #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_exc(if_exc),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata), .d_exc(d_exc),
        .fault_clr(fault_clr), .fault_valid(fault_valid),
        .fault_addr(fault_addr), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A usable address is word aligned and inside BASE .. BASE+4*DEPTH-1.
    function automatic bit good(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) % 4 == 0) && ((a - BASE) / 4 < DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    // One clock with the given requests; expectations come from the model.
    task automatic step(input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw, input logic [3:0] db,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input bit clr);
        bit          ifault, dfault;
        logic [31:0] e_ir, e_dr, word;
        logic [1:0]  e_ie, e_de;
        @(negedge clk);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_be = db;
        d_addr = da; d_wdata = dwd; fault_clr = clr;

        ifault = ir && !good(ia);
        dfault = dr && !good(da);
        e_ir = '0;
        if (ir && !ifault) begin
            e_ir = mdl[widx(ia)];
`ifdef ELBETH_MEM_BYPASS_EN
            if (dr && dw && !dfault && widx(ia) == widx(da))
                for (int i = 0; i < 4; i++)
                    if (db[i]) e_ir[8*i +: 8] = dwd[8*i +: 8];
`endif
        end
        e_ie = ifault ? 2'b01 : 2'b00;
        e_dr = (dr && !dw && !dfault) ? mdl[widx(da)] : '0;
        e_de = dfault ? (dw ? 2'b10 : 2'b11) : 2'b00;

        if ((ifault || dfault) && (!m_fv || clr)) begin
            m_fv = 1'b1;
            m_fa = dfault ? da : ia;
            m_fc = dfault ? e_de : 2'b01;
        end else if (clr) begin
            m_fv = 1'b0;
        end

        if (dr && dw && !dfault) begin
            word = mdl[widx(da)];
            for (int i = 0; i < 4; i++)
                if (db[i]) word[8*i +: 8] = dwd[8*i +: 8];
            mdl[widx(da)] = word;
        end

        @(posedge clk);
        #1;
        check("if_valid", 64'(if_valid), 64'(ir));
        check("if_rdata", 64'(if_rdata), 64'(e_ir));
        check("if_exc", 64'(if_exc), 64'(e_ie));
        check("d_valid", 64'(d_valid), 64'(dr));
        check("d_rdata", 64'(d_rdata), 64'(e_dr));
        check("d_exc", 64'(d_exc), 64'(e_de));
        check("fault_valid", 64'(fault_valid), 64'(m_fv));
        check("fault_addr", 64'(fault_addr), 64'(m_fa));
        check("fault_code", 64'(fault_code), 64'(m_fc));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // One clock with rst high and every request asserted; all outputs go to 0.
    task automatic reset_step(input logic [31:0] st_addr, input logic [31:0] st_data);
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h1002; d_req = 1'b1; d_we = 1'b1;
        d_be = 4'hF; d_addr = st_addr; d_wdata = st_data; fault_clr = 1'b1;
        m_fv = 1'b0; m_fa = '0; m_fc = '0;
        @(posedge clk);
        #1;
        check("rst if_valid", 64'(if_valid), 64'd0);
        check("rst if_rdata", 64'(if_rdata), 64'd0);
        check("rst if_exc", 64'(if_exc), 64'd0);
        check("rst d_valid", 64'(d_valid), 64'd0);
        check("rst d_rdata", 64'(d_rdata), 64'd0);
        check("rst d_exc", 64'(d_exc), 64'd0);
        check("rst fault_valid", 64'(fault_valid), 64'd0);
        check("rst fault_addr", 64'(fault_addr), 64'd0);
        check("rst fault_code", 64'(fault_code), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; fault_clr = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return BASE + 32'($urandom_range(0, 15) * 4);
        else if (r == 7) return BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 8) return BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else             return BASE + 32'(4 * DEPTH + $urandom_range(0, 15) * 4);
    endfunction

    initial begin
        // Power-on reset, then prove a request held during reset writes nothing.
        reset_step(32'h0, 32'h0BAD0BAD);
        step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
        reset_step(32'h0, 32'h12345678);
        step(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h0, '0, 1'b0);
        check("plan load 0 after reset", 64'(d_rdata), 64'h0000_0000_CAFE_F00D);

        // Fill every word so the model is fully defined from here on.
        for (int w = 0; w < DEPTH; w++)
            step(1'b0, '0, 1'b1, 1'b1, 4'hF, BASE + 32'(w * 4), $urandom, 1'b0);

        // Byte-enable merge.
        step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 4'h1, 32'h10, 32'h000000AA, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h10, '0, 1'b0);
        check("plan byte merge", 64'(d_rdata), 64'h0000_0000_DEAD_BEAA);

        // d_be=0 is a no-op store; misaligned store writes nothing.
        step(1'b0, '0, 1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h10, '0, 1'b0);
        check("be0 no-op", 64'(d_rdata), 64'h0000_0000_DEAD_BEAA);

        // First fault captured; a later load fault leaves it alone.
        step(1'b1, 32'h1002, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("plan fetch fault addr", 64'(fault_addr), 64'h1002);
        check("plan fetch fault code", 64'(fault_code), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 32'(4 * DEPTH), '0, 1'b0);
        check("plan load fault exc", 64'(d_exc), 64'd3);
        check("plan capture kept", 64'(fault_addr), 64'h1002);
        step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h21, 32'h55555555, 1'b0);

        // Both ports fault together with fault_clr: data port wins.
        step(1'b1, 32'h3, 1'b1, 1'b1, 4'hF, 32'(4 * DEPTH + 4), 32'h1, 1'b1);
        check("plan dual fault code", 64'(fault_code), 64'd2);
        check("plan dual fault addr", 64'(fault_addr), 64'(4 * DEPTH + 4));
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);

        // Same-cycle fetch and store to one word.
        step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h11111111, 1'b0);
        step(1'b1, 32'h20, 1'b1, 1'b1, 4'h3, 32'h20, 32'h22222222, 1'b0);
`ifdef ELBETH_MEM_BYPASS_EN
        check("plan bypass", 64'(if_rdata), 64'h0000_0000_1111_2222);
`else
        check("plan bypass", 64'(if_rdata), 64'h0000_0000_1111_1111);
`endif
        step(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("store visible next", 64'(if_rdata), 64'h0000_0000_1111_2222);

        // Back-to-back fetches.
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++)
            step(1'($urandom_range(0, 1)), rand_addr(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom), rand_addr(), $urandom,
                 $urandom_range(0, 7) == 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
